input_port: RTL and testbench

INPUT_PORT -- requirements
Module: input_port

---
 rtl/input_port_pkg.sv | 49 ++++
 rtl/input_port_buffer.sv | 136 +++++++++++++
 rtl/input_port.sv | 93 +++++++++
 tb/tb_input_port.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_port_pkg.sv
// Shared NoC parameters and types (package noc_params) used by the input port, its buffers and
// benches.
package noc_params;

    localparam int unsigned MESH_SIZE_X       = 4;
    localparam int unsigned MESH_SIZE_Y       = 4;
    localparam int unsigned VC_NUM            = 2;
    localparam int unsigned VC_SIZE           = $clog2(VC_NUM);
    localparam int unsigned DEST_ADDR_SIZE_X  = $clog2(MESH_SIZE_X);
    localparam int unsigned DEST_ADDR_SIZE_Y  = $clog2(MESH_SIZE_Y);
    localparam int unsigned FLIT_DATA_SIZE    = 16;
    localparam int unsigned HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X
                                                - DEST_ADDR_SIZE_Y;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEAD_TAIL} flit_label_t;

    typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

    // Head flits carry {x_dest, y_dest, payload} in data; other flits carry raw data.
    typedef struct packed {
        flit_label_t               flit_label;
        logic [VC_SIZE-1:0]        vc_id;
        logic [FLIT_DATA_SIZE-1:0] data;
    } flit_t;

    // Encoded so that every legal state is one-hot or zero.
    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StVa     = 2'b01,
        StActive = 2'b10
    } vc_state_t;

    function automatic logic is_head(input flit_label_t label);
        return (label == HEAD) || (label == HEAD_TAIL);
    endfunction

    function automatic logic is_tail(input flit_label_t label);
        return (label == TAIL) || (label == HEAD_TAIL);
    endfunction

    function automatic logic [DEST_ADDR_SIZE_X-1:0] x_dest(input flit_t f);
        return f.data[FLIT_DATA_SIZE-1 -: DEST_ADDR_SIZE_X];
    endfunction

    function automatic logic [DEST_ADDR_SIZE_Y-1:0] y_dest(input flit_t f);
        return f.data[HEAD_PAYLOAD_SIZE +: DEST_ADDR_SIZE_Y];
    endfunction

endpackage

// File: rtl/input_port_buffer.sv
// input_buffer: one virtual channel's flit FIFO plus its IDLE/VA/ACTIVE packet state machine.
// Optional checks are compiled in with INPUT_PORT_ASSERTIONS_EN.
module input_buffer
    import noc_params::*;
#(
    parameter int unsigned BUFFER_SIZE    = 8,
    parameter int unsigned PIPELINE_DEPTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  flit_t              data_i,
    input  logic               write_i,
    input  logic               read_i,
    input  logic [VC_SIZE-1:0] vc_new_i,
    input  logic               vc_valid_i,
    output flit_t              flit_o,
    output logic [VC_SIZE-1:0] vc_new_o,
    output logic               head_wr_o,
    output logic               on_off_o,
    output logic               vc_allocatable_o,
    output logic               vc_request_o,
    output logic               is_full_o,
    output logic               is_empty_o
);

    localparam int unsigned PtrW     = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam int unsigned CntW     = $clog2(BUFFER_SIZE + 1);
    localparam int unsigned OnOffThr = (BUFFER_SIZE > PIPELINE_DEPTH) ?
                                       (BUFFER_SIZE - PIPELINE_DEPTH) : 0;

    flit_t              mem_q [BUFFER_SIZE];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    vc_state_t          state_q, state_d;
    logic [VC_SIZE-1:0] vc_new_q, vc_new_d;
    logic               wr_legal, wr_en, rd_en;
    flit_t              front;

    assign is_full_o        = (count_q == CntW'(BUFFER_SIZE));
    assign is_empty_o       = (count_q == '0);
    assign on_off_o         = (count_q <= CntW'(OnOffThr));
    assign vc_request_o     = (state_q == StVa);
    assign vc_allocatable_o = (state_q == StIdle);
    assign vc_new_o         = vc_new_q;

    assign front  = mem_q[rd_ptr_q];
    assign flit_o = is_empty_o ? '0 : front;

    // Heads open a packet only from IDLE; body/tail only continue an open packet.
    assign wr_legal  = is_head(data_i.flit_label) ? (state_q == StIdle) : (state_q != StIdle);
    assign wr_en     = write_i && wr_legal && !is_full_o;
    assign rd_en     = read_i && (state_q == StActive) && !is_empty_o;
    assign head_wr_o = wr_en && is_head(data_i.flit_label);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(BUFFER_SIZE - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(BUFFER_SIZE - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + CntW'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        vc_new_d = vc_new_q;
        unique case (state_q)
            StIdle: begin
                if (wr_en) begin
                    state_d = StVa;
                end
            end
            StVa: begin
                if (vc_valid_i) begin
                    state_d  = StActive;
                    vc_new_d = vc_new_i;
                end
            end
            StActive: begin
                if (rd_en && is_tail(front.flit_label)) begin
                    state_d  = StIdle;
                    vc_new_d = '0;
                end
            end
            default: begin
                state_d  = StIdle;
                vc_new_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StIdle;
            vc_new_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            vc_new_q <= vc_new_d;
        end
    end

    // Storage needs no reset: the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

`ifdef INPUT_PORT_ASSERTIONS_EN
    a_no_full_write: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && (count_q == CntW'(BUFFER_SIZE))));
    a_no_empty_pop: assert property (@(posedge clk) disable iff (rst)
        !(rd_en && (count_q == '0)));
    a_state_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(state_q));
    a_request_not_empty: assert property (@(posedge clk) disable iff (rst)
        vc_request_o |-> !is_empty_o);
`else
    // Checks compiled out; datapath and control are unchanged.
`endif

endmodule

// File: rtl/input_port.sv
// input_port: VC_NUM input_buffer instances, XY route latch per VC and the switch-side output mux.
// Define INPUT_PORT_ASSERTIONS_EN to compile in the buffer protocol checks.
module input_port
    import noc_params::*;
#(
    parameter int unsigned BUFFER_SIZE    = 8,
    parameter int unsigned PIPELINE_DEPTH = 5,
    parameter int unsigned X_CURRENT      = MESH_SIZE_X / 2,
    parameter int unsigned Y_CURRENT      = MESH_SIZE_Y / 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  flit_t                           data_i,
    input  logic                            valid_flit_i,
    input  logic [VC_SIZE-1:0]              vc_sel_i,
    input  logic                            valid_sel_i,
    input  logic [VC_NUM-1:0][VC_SIZE-1:0]  vc_new_i,
    input  logic [VC_NUM-1:0]               vc_valid_i,
    output flit_t                           flit_o,
    output logic [VC_NUM-1:0]               on_off_o,
    output logic [VC_NUM-1:0]               vc_allocatable_o,
    output logic [VC_NUM-1:0]               vc_request_o,
    output logic [VC_NUM-1:0]               is_full_o,
    output logic [VC_NUM-1:0]               is_empty_o,
    output port_t [VC_NUM-1:0]              out_port_o
);

    flit_t              buf_flit   [VC_NUM];
    logic [VC_SIZE-1:0] buf_vc_new [VC_NUM];
    logic [VC_NUM-1:0]  head_wr;
    logic [VC_NUM-1:0]  wr_sel, rd_sel;

    function automatic port_t route(input flit_t f);
        logic [31:0] xd, yd;
        xd = 32'(x_dest(f));
        yd = 32'(y_dest(f));
        if (xd > X_CURRENT) return EAST;
        if (xd < X_CURRENT) return WEST;
        if (yd > Y_CURRENT) return SOUTH;
        if (yd < Y_CURRENT) return NORTH;
        return LOCAL;
    endfunction

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        port_t out_port_q;

        assign wr_sel[v] = valid_flit_i && (data_i.vc_id == VC_SIZE'(v));
        assign rd_sel[v] = valid_sel_i && (vc_sel_i == VC_SIZE'(v));

        input_buffer #(
            .BUFFER_SIZE    (BUFFER_SIZE),
            .PIPELINE_DEPTH (PIPELINE_DEPTH)
        ) u_buf (
            .clk              (clk),
            .rst              (rst),
            .data_i           (data_i),
            .write_i          (wr_sel[v]),
            .read_i           (rd_sel[v]),
            .vc_new_i         (vc_new_i[v]),
            .vc_valid_i       (vc_valid_i[v]),
            .flit_o           (buf_flit[v]),
            .vc_new_o         (buf_vc_new[v]),
            .head_wr_o        (head_wr[v]),
            .on_off_o         (on_off_o[v]),
            .vc_allocatable_o (vc_allocatable_o[v]),
            .vc_request_o     (vc_request_o[v]),
            .is_full_o        (is_full_o[v]),
            .is_empty_o       (is_empty_o[v])
        );

        // Route is held for the whole packet; only an accepted head updates it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_port_q <= LOCAL;
            end else if (head_wr[v]) begin
                out_port_q <= route(data_i);
            end
        end

        assign out_port_o[v] = out_port_q;
    end

    always_comb begin
        flit_o = '0;
        for (int unsigned v = 0; v < VC_NUM; v++) begin
            if ((vc_sel_i == VC_SIZE'(v)) && !is_empty_o[v]) begin
                flit_o       = buf_flit[v];
                flit_o.vc_id = buf_vc_new[v];
            end
        end
    end

endmodule

// File: tb/tb_input_port.sv
// Bench for input_port: directed packet scenarios then random traffic against a queue-based model.
module tb_input_port;
    import noc_params::*;

    localparam int BufSize   = 8;
    localparam int PipeDepth = 5;
    localparam int Xc        = MESH_SIZE_X / 2;
    localparam int Yc        = MESH_SIZE_Y / 2;
    localparam int VnW       = VC_NUM * VC_SIZE;

    logic                           clk = 1'b0;
    logic                           rst;
    flit_t                          data_i;
    logic                           valid_flit_i;
    logic [VC_SIZE-1:0]             vc_sel_i;
    logic                           valid_sel_i;
    logic [VC_NUM-1:0][VC_SIZE-1:0] vc_new_i;
    logic [VC_NUM-1:0]              vc_valid_i;
    flit_t                          flit_o;
    logic [VC_NUM-1:0]              on_off_o, vc_allocatable_o, vc_request_o;
    logic [VC_NUM-1:0]              is_full_o, is_empty_o;
    port_t [VC_NUM-1:0]             out_port_o;

    input_port #(
        .BUFFER_SIZE    (BufSize),
        .PIPELINE_DEPTH (PipeDepth)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .data_i           (data_i),
        .valid_flit_i     (valid_flit_i),
        .vc_sel_i         (vc_sel_i),
        .valid_sel_i      (valid_sel_i),
        .vc_new_i         (vc_new_i),
        .vc_valid_i       (vc_valid_i),
        .flit_o           (flit_o),
        .on_off_o         (on_off_o),
        .vc_allocatable_o (vc_allocatable_o),
        .vc_request_o     (vc_request_o),
        .is_full_o        (is_full_o),
        .is_empty_o       (is_empty_o),
        .out_port_o       (out_port_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: per-VC flit queue, "packet open" and "granted" flags, granted VC, route.
    flit_t              mq      [VC_NUM][$];
    bit                 m_pkt   [VC_NUM];
    bit                 m_gnt   [VC_NUM];
    logic [VC_SIZE-1:0] m_new   [VC_NUM];
    port_t              m_route [VC_NUM];

    function automatic port_t ref_route(input int x, input int y);
        if (x > Xc) return EAST;
        if (x < Xc) return WEST;
        if (y > Yc) return SOUTH;
        if (y < Yc) return NORTH;
        return LOCAL;
    endfunction

    function automatic flit_t mk(input flit_label_t l, input int vc, input int x, input int y,
                                 input int pl);
        flit_t f;
        f.flit_label = l;
        f.vc_id      = VC_SIZE'(vc);
        f.data       = FLIT_DATA_SIZE'((x << (HEAD_PAYLOAD_SIZE + DEST_ADDR_SIZE_Y)) |
                                       (y << HEAD_PAYLOAD_SIZE) |
                                       (pl % (1 << HEAD_PAYLOAD_SIZE)));
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int v = 0; v < VC_NUM; v++) begin
            mq[v].delete();
            m_pkt[v]   = 1'b0;
            m_gnt[v]   = 1'b0;
            m_new[v]   = '0;
            m_route[v] = LOCAL;
        end
    endtask

    task automatic check_all(input string tag);
        flit_t ef;
        int    s;
        for (int v = 0; v < VC_NUM; v++) begin
            chk($sformatf("%s empty[%0d]", tag, v), 64'(is_empty_o[v]), 64'(mq[v].size() == 0));
            chk($sformatf("%s full[%0d]", tag, v), 64'(is_full_o[v]),
                64'(mq[v].size() == BufSize));
            chk($sformatf("%s on_off[%0d]", tag, v), 64'(on_off_o[v]),
                64'(mq[v].size() <= BufSize - PipeDepth));
            chk($sformatf("%s req[%0d]", tag, v), 64'(vc_request_o[v]),
                64'(m_pkt[v] && !m_gnt[v]));
            chk($sformatf("%s alloc[%0d]", tag, v), 64'(vc_allocatable_o[v]), 64'(!m_pkt[v]));
            chk($sformatf("%s port[%0d]", tag, v), 64'(out_port_o[v]), 64'(m_route[v]));
        end
        s  = int'(vc_sel_i);
        ef = '0;
        if (mq[s].size() > 0) begin
            ef       = mq[s][0];
            ef.vc_id = m_new[s];
        end
        chk($sformatf("%s flit", tag), 64'(flit_o), 64'(ef));
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit    push [VC_NUM];
        bit    pop  [VC_NUM];
        bit    hd;
        flit_t f;
        int    d;
        hd = (data_i.flit_label == HEAD) || (data_i.flit_label == HEAD_TAIL);
        for (int v = 0; v < VC_NUM; v++) begin
            push[v] = valid_flit_i && (int'(data_i.vc_id) == v) && (mq[v].size() < BufSize) &&
                      (hd ? !m_pkt[v] : m_pkt[v]);
            pop[v]  = valid_sel_i && (int'(vc_sel_i) == v) && m_pkt[v] && m_gnt[v] &&
                      (mq[v].size() > 0);
        end
        for (int v = 0; v < VC_NUM; v++) begin
            if (pop[v]) begin
                f = mq[v].pop_front();
                if (f.flit_label == TAIL || f.flit_label == HEAD_TAIL) begin
                    m_pkt[v] = 1'b0;
                    m_gnt[v] = 1'b0;
                    m_new[v] = '0;
                end
            end else if (m_pkt[v] && !m_gnt[v] && vc_valid_i[v]) begin
                m_gnt[v] = 1'b1;
                m_new[v] = vc_new_i[v];
            end
            if (push[v]) begin
                mq[v].push_back(data_i);
                if (hd) begin
                    d          = int'(data_i.data);
                    m_pkt[v]   = 1'b1;
                    m_gnt[v]   = 1'b0;
                    m_route[v] = ref_route(d >> (HEAD_PAYLOAD_SIZE + DEST_ADDR_SIZE_Y),
                                           (d >> HEAD_PAYLOAD_SIZE) % (1 << DEST_ADDR_SIZE_Y));
                end
            end
        end
    endtask

    // Called at a falling edge with inputs set; checks, clocks once, clears strobes.
    task automatic tick(input string tag);
        #1;
        check_all(tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        valid_flit_i = 1'b0;
        valid_sel_i  = 1'b0;
        vc_valid_i   = '0;
    endtask

    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_clear();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    flit_label_t lbl [4];

    initial begin
        lbl          = '{HEAD, BODY, BODY, TAIL};
        rst          = 1'b1;
        data_i       = '0;
        valid_flit_i = 1'b0;
        vc_sel_i     = '0;
        valid_sel_i  = 1'b0;
        vc_new_i     = '0;
        vc_valid_i   = '0;
        model_clear();
        #3;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // 4-flit packet on VC1 back-to-back, granted VC0 in the third cycle.
        for (int i = 0; i < 4; i++) begin
            data_i       = mk(lbl[i], 1, 3, 1, 'h11 * (i + 1));
            valid_flit_i = 1'b1;
            if (i == 2) begin
                vc_valid_i  = 2'b10;
                vc_new_i[1] = '0;
            end
            if (i == 3) begin
                valid_sel_i = 1'b1;
                vc_sel_i    = 1'b1;
            end
            tick("pkt4");
        end
        repeat (5) begin
            valid_sel_i = 1'b1;
            vc_sel_i    = 1'b1;
            tick("pkt4_rd");
        end

        // Same packet on VC0 with idle gaps, reader polling every cycle.
        for (int i = 0; i < 4; i++) begin
            data_i       = mk(lbl[i], 0, 0, 2, 'h50 + i);
            valid_flit_i = 1'b1;
            valid_sel_i  = 1'b1;
            vc_sel_i     = 1'b0;
            tick("gap_wr");
            for (int g = 0; g < 2; g++) begin
                valid_sel_i = 1'b1;
                vc_sel_i    = 1'b0;
                if (i == 0 && g == 0) begin
                    vc_valid_i  = 2'b01;
                    vc_new_i[0] = 1'b1;
                end
                tick("gap_idle");
            end
        end

        // HEAD then TAIL on VC1, granted together with the tail write.
        data_i       = mk(HEAD, 1, 2, 3, 'h70);
        valid_flit_i = 1'b1;
        tick("ht_head");
        data_i       = mk(TAIL, 1, 0, 0, 'h71);
        valid_flit_i = 1'b1;
        vc_valid_i   = 2'b10;
        vc_new_i[1]  = 1'b1;
        tick("ht_tail");
        repeat (3) begin
            valid_sel_i = 1'b1;
            vc_sel_i    = 1'b1;
            tick("ht_rd");
        end

        // BODY and TAIL with no open packet are dropped.
        data_i       = mk(BODY, 0, 1, 1, 'h80);
        valid_flit_i = 1'b1;
        tick("orphan_body");
        data_i       = mk(TAIL, 0, 1, 1, 'h81);
        valid_flit_i = 1'b1;
        tick("orphan_tail");
        tick("orphan_after");

        // Nine writes with no reads: full after eight, ninth dropped.
        for (int i = 0; i < 9; i++) begin
            data_i       = mk((i == 0) ? HEAD : BODY, 0, 2, 0, 'h90 + i);
            valid_flit_i = 1'b1;
            tick("fill");
        end
        vc_valid_i  = 2'b01;
        vc_new_i[0] = 1'b0;
        tick("fill_gnt");
        repeat (9) begin
            valid_sel_i = 1'b1;
            vc_sel_i    = 1'b0;
            tick("drain");
        end
        data_i       = mk(TAIL, 0, 0, 0, 'h9f);
        valid_flit_i = 1'b1;
        tick("drain_tail");
        repeat (2) begin
            valid_sel_i = 1'b1;
            vc_sel_i    = 1'b0;
            tick("drain_tail_rd");
        end

        // Second HEAD while VC waits for allocation must not move the route.
        data_i       = mk(HEAD, 0, 3, 2, 'ha0);
        valid_flit_i = 1'b1;
        tick("head_east");
        data_i       = mk(HEAD, 0, 0, 2, 'ha1);
        valid_flit_i = 1'b1;
        tick("head_dup");
        tick("head_dup_after");

        // Reset in the middle of a packet.
        do_reset("rst_mid");
        tick("rst_after");

        repeat (800) begin
            valid_flit_i = ($urandom_range(0, 3) != 0);
            data_i       = mk(flit_label_t'($urandom_range(0, 3)),
                              $urandom_range(0, VC_NUM - 1),
                              $urandom_range(0, MESH_SIZE_X - 1),
                              $urandom_range(0, MESH_SIZE_Y - 1), $urandom_range(0, 4095));
            valid_sel_i  = $urandom_range(0, 1);
            vc_sel_i     = VC_SIZE'($urandom_range(0, VC_NUM - 1));
            vc_valid_i   = VC_NUM'($urandom);
            vc_new_i     = VnW'($urandom);
            tick("rnd");
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd_rst");
            end
        end

        #1;
        check_all("end");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
